// File: rtl/flash_loader.sv
// rtl/flash_loader.sv - byte-stream boot image loader writing words to flash (optional FLASH_LOADER_CHECKSUM_EN)
module flash_loader #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] BASE_ADDR = '0,
    parameter int               MAX_WORDS = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    output logic             flash_en,
    output logic [WIDTH-1:0] flash_addr,
    output logic [WIDTH-1:0] flash_data,
    output logic             cpu_hold,
    output logic             done,
    output logic             error
);

`ifdef FLASH_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR, S_CSUM} state_t;
    localparam state_t S_END = S_CSUM;
`else
    typedef enum logic [2:0] {S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR} state_t;
    localparam state_t S_END = S_DONE;
`endif

    state_t      state, state_nxt;
    logic [1:0]  byte_cnt;
    logic [23:0] shift_q;
    logic [31:0] len_q;
    logic [31:0] word_idx;
    logic [31:0] word_full;
    logic        accept;
    logic        last_byte;
    logic        collecting;
`ifdef FLASH_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    assign accept     = rx_valid && rx_ready;
    assign last_byte  = accept && (byte_cnt == 2'd3);
    assign word_full  = {rx_data, shift_q};
    assign collecting = (state == S_LEN) || (state == S_DATA);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_LEN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LEN: begin
                if (last_byte) begin
                    if (word_full == 32'd0)
                        state_nxt = S_END;
                    else if (word_full > 32'(MAX_WORDS))
                        state_nxt = S_ERR;
                    else
                        state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (last_byte)
                    state_nxt = S_WRITE;
            end
            S_WRITE: begin
                state_nxt = (word_idx + 32'd1 == len_q) ? S_END : S_DATA;
            end
`ifdef FLASH_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept)
                    state_nxt = (rx_data == csum_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_nxt = state;
        endcase
    end

    always_comb begin
        rx_ready = 1'b0;
        flash_en = 1'b0;
        cpu_hold = 1'b1;
        done     = 1'b0;
        error    = 1'b0;
        case (state)
            S_LEN, S_DATA: rx_ready = 1'b1;
`ifdef FLASH_LOADER_CHECKSUM_EN
            S_CSUM:        rx_ready = 1'b1;
`endif
            S_WRITE:       flash_en = 1'b1;
            S_DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            S_ERR:         error = 1'b1;
            default:       rx_ready = 1'b0;
        endcase
    end

    // Address/data are loaded on the 4th byte so they are valid throughout WRITE and held afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt   <= 2'd0;
            shift_q    <= 24'd0;
            len_q      <= 32'd0;
            word_idx   <= 32'd0;
            flash_addr <= '0;
            flash_data <= '0;
`ifdef FLASH_LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            if (accept && collecting) begin
                byte_cnt <= byte_cnt + 2'd1;
                shift_q  <= {rx_data, shift_q[23:8]};
`ifdef FLASH_LOADER_CHECKSUM_EN
                csum_q   <= csum_q ^ rx_data;
`endif
            end
            if (state == S_LEN && last_byte)
                len_q <= word_full;
            if (state == S_DATA && last_byte) begin
                flash_data <= WIDTH'(word_full);
                flash_addr <= BASE_ADDR + (WIDTH'(word_idx) << 2);
            end
            if (state == S_WRITE)
                word_idx <= word_idx + 32'd1;
        end
    end

endmodule

// File: tb/tb_flash_loader.sv
// tb/tb_flash_loader.sv - self-checking bench for flash_loader against a stream-level model
module tb_flash_loader;

    localparam int MAX = 256;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready;
    logic        flash_en;
    logic [31:0] flash_addr;
    logic [31:0] flash_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    int unsigned exp_cyc_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic        exp_en;
    logic [31:0] ea, ed;

    flash_loader #(.WIDTH(32), .BASE_ADDR(32'h0), .MAX_WORDS(MAX)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .flash_en(flash_en), .flash_addr(flash_addr),
        .flash_data(flash_data), .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle: a write strobe appears exactly when the model scheduled one, carrying the model's word.
    always @(negedge clk) begin
        if (rst) begin
            exp_en = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
            checks++;
            if (flash_en !== exp_en) begin
                errors++;
                $display("FAIL flash_en cyc=%0d got %b exp %b", cyc, flash_en, exp_en);
            end
            if (exp_en) begin
                void'(exp_cyc_q.pop_front());
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                checks++;
                if (flash_addr !== ea || flash_data !== ed) begin
                    errors++;
                    $display("FAIL write cyc=%0d got %h/%h exp %h/%h", cyc, flash_addr, flash_data, ea, ed);
                end
            end
            checks++;
            if (cpu_hold !== ~done || (done && error)) begin
                errors++;
                $display("FAIL status_rule got hold=%b done=%b err=%b", cpu_hold, done, error);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Offer one byte (called just after a negedge); wr marks the byte that completes a data word.
    task automatic send_byte(input logic [7:0] b, input bit wr);
        bit r;
        r = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int t = 0; t < 20 && !r; t++) begin
            r = rx_ready;
            if (r && wr) exp_cyc_q.push_back(cyc + 1);
            @(negedge clk);
        end
        if (!r) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout byte %h not accepted", b);
        end
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rst = 1'b0;
        exp_cyc_q.delete();
        exp_addr_q.delete();
        exp_data_q.delete();
        @(negedge clk);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        chk("rst_flash_en", {31'd0, flash_en}, 32'd0);
        chk("rst_flash_addr", flash_addr, 32'd0);
        chk("rst_flash_data", flash_data, 32'd0);
        chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Model: derive the writes and final outcome from the stream bytes, then drive the stream.
    task automatic run_stream(input string name, input bq_t s_in, input int gap, input bit auto_csum);
        bq_t         s;
        logic [31:0] n;
        int          nwr;
        int          st;
        logic [7:0]  x;
        s   = s_in;
        n   = {s[3], s[2], s[1], s[0]};
        nwr = (n > 32'(MAX)) ? 0 : int'(n);
        x   = 8'd0;
        for (int i = 0; i < 4 + 4 * nwr; i++) x ^= s[i];
`ifdef FLASH_LOADER_CHECKSUM_EN
        if (auto_csum && n <= 32'(MAX)) s.push_back(x);
`else
        if (auto_csum) x = 8'd0;
`endif
        for (int k = 0; k < nwr; k++) begin
            exp_addr_q.push_back(32'h0 + 32'(4 * k));
            exp_data_q.push_back({s[4*k+7], s[4*k+6], s[4*k+5], s[4*k+4]});
        end
        if (n > 32'(MAX)) st = 2;
`ifdef FLASH_LOADER_CHECKSUM_EN
        else st = (s[4 + 4 * nwr] == x) ? 1 : 2;
`else
        else st = 1;
`endif
        for (int i = 0; i < s.size(); i++) begin
            send_byte(s[i], (i >= 4) && (i < 4 + 4 * nwr) && ((i - 4) % 4 == 3));
            if (gap > 0 && i + 1 < s.size()) idle(gap);
        end
        idle(3);
        chk({name, "_done"}, {31'd0, done}, {31'd0, st == 1});
        chk({name, "_error"}, {31'd0, error}, {31'd0, st == 2});
        chk({name, "_hold"}, {31'd0, cpu_hold}, {31'd0, st != 1});
        chk({name, "_ready_after"}, {31'd0, rx_ready}, 32'd0);
        chk({name, "_writes_left"}, exp_cyc_q.size(), 32'd0);
    endtask

    initial begin
        bq_t s;
        @(negedge clk);
        do_reset();

        s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h50, 8'h00};
        run_stream("two_words", s, 0, 1'b1);
        chk("two_words_addr_held", flash_addr, 32'h4);
        chk("two_words_data_held", flash_data, 32'h005000B3);

        do_reset();
`ifdef FLASH_LOADER_CHECKSUM_EN
        s = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_stream("zero_len", s, 0, 1'b1);
`else
        for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b0);
        chk("zero_len_done_next", {31'd0, done}, 32'd1);
        idle(3);
        chk("zero_len_done", {31'd0, done}, 32'd1);
        chk("zero_len_hold", {31'd0, cpu_hold}, 32'd0);
`endif

        do_reset();
        s = '{8'h01, 8'h01, 8'h00, 8'h00};
        run_stream("too_long", s, 0, 1'b1);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("too_long_no_accept", {31'd0, rx_ready}, 32'd0);
        end
        idle(1);
        chk("too_long_error", {31'd0, error}, 32'd1);

        do_reset();
        s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        run_stream("stall", s, 2, 1'b1);
        chk("stall_data", flash_data, 32'h12345678);

        do_reset();
        send_byte(8'h01, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        do_reset();
        s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h0D, 8'hF0, 8'hAD, 8'h0B};
        run_stream("reset_mid", s, 0, 1'b1);
        chk("reset_mid_addr", flash_addr, 32'h0);
        chk("reset_mid_data", flash_data, 32'h0BADF00D);

        do_reset();
        s = '{8'h00, 8'h01, 8'h00, 8'h00};
        for (int k = 0; k < MAX; k++) begin
            s.push_back(8'h3C);
            s.push_back(~k[7:0]);
            s.push_back(k[7:0]);
            s.push_back(k[7:0] ^ 8'hA5);
        end
        run_stream("max_len", s, 0, 1'b1);
        chk("max_len_last_addr", flash_addr, 32'h3FC);

`ifdef FLASH_LOADER_CHECKSUM_EN
        do_reset();
        s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23};
        run_stream("csum_good", s, 0, 1'b0);
        chk("csum_good_done", {31'd0, done}, 32'd1);
        chk("csum_good_data", flash_data, 32'hDEADBEEF);
        do_reset();
        s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h24};
        run_stream("csum_bad", s, 0, 1'b0);
        chk("csum_bad_error", {31'd0, error}, 32'd1);
        chk("csum_bad_data", flash_data, 32'hDEADBEEF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flash_loader.md
FLASH_LOADER -- requirements
Module: flash_loader

Interface
REQ-001 Parameter WIDTH, default 32, data and address width of the flash write port.
REQ-002 Parameter BASE_ADDR, default 0, byte address of the first word written.
REQ-003 Parameter MAX_WORDS, default 256, largest accepted image length in words.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 rx_valid  input  1  a byte is offered on rx_data.
REQ-007 rx_data  input  8  offered byte.
REQ-008 rx_ready  output  1  loader accepts a byte this cycle; transfer occurs when rx_valid and rx_ready are both high at a rising edge.
REQ-009 flash_en  output  1  one-cycle write strobe to the datapath flash port.
REQ-010 flash_addr  output  WIDTH  byte address of the word being written.
REQ-011 flash_data  output  WIDTH  word being written.
REQ-012 cpu_hold  output  1  high while the core must not run (loading in progress).
REQ-013 done  output  1  image loaded successfully; sticky.
REQ-014 error  output  1  image rejected; sticky.

Function
REQ-015 Stream format SHALL be: 4-byte little-endian word count N, then N words, each 4 bytes little-endian, then (only with checksum enabled) 1 checksum byte.
REQ-016 The FSM SHALL have states LEN, DATA, WRITE, CSUM, DONE, ERR; reset enters LEN.
REQ-017 rx_ready SHALL be 1 in LEN, DATA, CSUM and 0 in WRITE, DONE, ERR.
REQ-018 LEN: after the 4th byte is accepted, N=0 -> CSUM (enabled) or DONE (disabled); N>MAX_WORDS -> ERR; otherwise -> DATA.
REQ-019 DATA: bytes assemble into a word, byte k at bits [8k+7:8k]; after the 4th byte is accepted the next state is WRITE.
REQ-020 WRITE lasts exactly one cycle with flash_en=1, flash_addr=BASE_ADDR+4*i (i = 0-based word index, WIDTH-bit modulo arithmetic), flash_data=assembled word; flash_en SHALL be 0 in every other state.
REQ-021 Write latency: flash_en is high in the cycle immediately following acceptance of a word's 4th byte.
REQ-022 After WRITE: if i+1 == N -> CSUM (enabled) or DONE (disabled); else -> DATA with i incremented.
REQ-023 flash_addr and flash_data SHALL hold their last written values outside WRITE.
REQ-024 rx_valid low for any number of cycles SHALL stall the FSM with no state change and no lost byte.
REQ-025 DONE and ERR are terminal until reset; bytes offered there are not accepted.
REQ-026 cpu_hold SHALL be 1 in all states except DONE; done=1 only in DONE; error=1 only in ERR.

Reset
REQ-027 Asserting rst at any time, including mid-word or mid-WRITE, SHALL immediately force state LEN, rx_ready=1, flash_en=0, flash_addr=0, flash_data=0, cpu_hold=1, done=0, error=0, byte/word counters and checksum accumulator to 0.
REQ-028 A partially received word at reset SHALL be discarded and never written.

Configuration
REQ-029 Macro FLASH_LOADER_CHECKSUM_EN, when defined, SHALL compile in the CSUM state and an 8-bit accumulator XORing every accepted byte from the first length byte through the last data byte.
REQ-030 With FLASH_LOADER_CHECKSUM_EN defined, in CSUM the accepted byte equal to the accumulator -> DONE, otherwise -> ERR (words already written remain written).
REQ-031 With FLASH_LOADER_CHECKSUM_EN undefined, CSUM and the accumulator SHALL not exist and the stream ends after the last data word.

Verification
REQ-032 Stream 02 00 00 00, 13 00 00 00, B3 00 50 00 (checksum off) -> flash_en pulses with (0x0, 0x00000013) then (0x4, 0x005000B3); done=1, cpu_hold=0.
REQ-033 Stream 00 00 00 00 (checksum off) -> no flash_en pulse; done=1 in the cycle after the 4th byte.
REQ-034 Length 01 01 00 00 (257) with MAX_WORDS=256 -> error=1, no flash_en, rx_ready=0 thereafter.
REQ-035 Checksum on, stream 01 00 00 00 EF BE AD DE then 0x23 -> write (0x0, 0xDEADBEEF), done=1; same stream with final byte 0x24 -> write occurs, error=1.
REQ-036 rx_valid toggled 1-0-0-1 between bytes of 1-word image 78 56 34 12 -> single write of 0x12345678, one-cycle flash_en.
REQ-037 rst asserted after 2 data bytes of word 0, then full 1-word stream resent -> exactly one flash_en, address BASE_ADDR, data from resent bytes.
